multicycle_controller: RTL and testbench

- Parametrised multi-cycle control unit for the RV32I core; successor to the single-cycle combinational controller.
- Latches the fetched instruction, then sequences FETCH/DECODE/EXEC/MEM/WB through an FSM and drives datapath enables and ALU control per state.
- Adds memory wait-state handshake with timeout, illegal-instruction trap, ECALL halt, a wider decoded instruction set, and x0-write suppression.

---
 rtl/multicycle_controller.sv | 229 ++++++++++++++++++++++
 tb/tb_multicycle_controller.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/multicycle_controller.sv
// Multi-cycle RV32I control unit: latches the fetched instruction and sequences
// FETCH/DECODE/EXEC/MEM/WB, with memory wait states, timeout trap, illegal trap and ECALL halt.
module multicycle_controller #(
  parameter int WORD        = 32,
  parameter int ALU_W       = 4,
  parameter int MEM_TIMEOUT = 15
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             instrValid,
  input  logic [WORD-1:0]  instr,
  input  logic             memReady,
  output logic             instrReq,
  output logic             irLoad,
  output logic             regWrite,
  output logic             memRead,
  output logic             memWrite,
  output logic             aluSrcImm,
  output logic [ALU_W-1:0] aluControl,
  output logic             pcWrite,
  output logic             ecall,
  output logic             illegalInstr,
  output logic             memTimeout,
  output logic [2:0]       state
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5,
    S_TRAP   = 3'd6
  } state_t;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  localparam logic [ALU_W-1:0] ALU_ADD   = ALU_W'(0);
  localparam logic [ALU_W-1:0] ALU_SUB   = ALU_W'(1);
  localparam logic [ALU_W-1:0] ALU_AND   = ALU_W'(2);
  localparam logic [ALU_W-1:0] ALU_OR    = ALU_W'(3);
  localparam logic [ALU_W-1:0] ALU_XOR   = ALU_W'(4);
  localparam logic [ALU_W-1:0] ALU_SLT   = ALU_W'(5);
  localparam logic [ALU_W-1:0] ALU_SLTU  = ALU_W'(6);
  localparam logic [ALU_W-1:0] ALU_SLL   = ALU_W'(7);
  localparam logic [ALU_W-1:0] ALU_SRL   = ALU_W'(8);
  localparam logic [ALU_W-1:0] ALU_SRA   = ALU_W'(9);
  localparam logic [ALU_W-1:0] ALU_PASSB = ALU_W'(10);

  localparam int CNT_W = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT);
  localparam int LIMIT = (MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0;

  state_t            r_state;
  state_t            w_next_state;
  logic [WORD-1:0]   r_ir;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_illegal;
  logic              r_timeout;

  logic [6:0]        w_opcode;
  logic [2:0]        w_f3;
  logic [6:0]        w_f7;
  logic [4:0]        w_rd;
  logic              w_legal;
  logic              w_is_ecall;
  logic              w_is_load;
  logic              w_is_store;
  logic              w_use_imm;
  logic [ALU_W-1:0]  w_alu;
  logic              w_mem_expire;

  assign w_opcode   = r_ir[6:0];
  assign w_rd       = r_ir[11:7];
  assign w_f3       = r_ir[14:12];
  assign w_f7       = r_ir[31:25];
  assign w_is_load  = (w_opcode == OPC_LOAD);
  assign w_is_store = (w_opcode == OPC_STORE);
  assign w_is_ecall = (w_opcode == OPC_SYSTEM) && (r_ir[31:7] == 25'd0);

  function automatic logic [ALU_W-1:0] alu_from_f3(input logic [2:0] f3, input logic alt);
    case (f3)
      3'b000:  alu_from_f3 = alt ? ALU_SUB : ALU_ADD;
      3'b001:  alu_from_f3 = ALU_SLL;
      3'b010:  alu_from_f3 = ALU_SLT;
      3'b011:  alu_from_f3 = ALU_SLTU;
      3'b100:  alu_from_f3 = ALU_XOR;
      3'b101:  alu_from_f3 = alt ? ALU_SRA : ALU_SRL;
      3'b110:  alu_from_f3 = ALU_OR;
      default: alu_from_f3 = ALU_AND;
    endcase
  endfunction

  // Instruction classification; only funct7 bit 5 selects the alternate op.
  always_comb begin
    w_legal   = 1'b0;
    w_use_imm = 1'b0;
    w_alu     = ALU_ADD;
    case (w_opcode)
      OPC_LOAD, OPC_STORE: begin
        w_legal   = (w_f3 == 3'b010);
        w_use_imm = 1'b1;
      end
      OPC_OP_IMM: begin
        w_use_imm = 1'b1;
        if (w_f3 == 3'b001) begin
          w_legal = (w_f7 == 7'b0000000);
          w_alu   = ALU_SLL;
        end else if (w_f3 == 3'b101) begin
          w_legal = (w_f7 == 7'b0000000) || (w_f7 == 7'b0100000);
          w_alu   = alu_from_f3(w_f3, w_f7[5]);
        end else begin
          w_legal = 1'b1;
          w_alu   = alu_from_f3(w_f3, 1'b0);
        end
      end
      OPC_OP: begin
        w_legal = (w_f7 == 7'b0000000) ||
                  ((w_f7 == 7'b0100000) && ((w_f3 == 3'b000) || (w_f3 == 3'b101)));
        w_alu   = alu_from_f3(w_f3, w_f7[5]);
      end
      OPC_LUI: begin
        w_legal   = 1'b1;
        w_use_imm = 1'b1;
        w_alu     = ALU_PASSB;
      end
      default: w_legal = 1'b0;
    endcase
  end

  generate
    if (MEM_TIMEOUT > 0) begin : g_timeout
      assign w_mem_expire = !memReady && (r_cnt == CNT_W'(LIMIT));
    end else begin : g_no_timeout
      assign w_mem_expire = 1'b0;
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= S_FETCH;
    else        r_state <= w_next_state;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_ir      <= '0;
      r_cnt     <= '0;
      r_illegal <= 1'b0;
      r_timeout <= 1'b0;
    end else begin
      if (r_state == S_FETCH && instrValid) r_ir <= instr;
      if (r_state == S_MEM && !memReady && !w_mem_expire) r_cnt <= r_cnt + 1'b1;
      else                                                r_cnt <= '0;
      if (r_state == S_DECODE && !w_is_ecall && !w_legal) r_illegal <= 1'b1;
      if (r_state == S_MEM && w_mem_expire)               r_timeout <= 1'b1;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_FETCH:  if (instrValid) w_next_state = S_DECODE;
      S_DECODE: begin
        if (w_is_ecall)   w_next_state = S_HALT;
        else if (w_legal) w_next_state = S_EXEC;
        else              w_next_state = S_TRAP;
      end
      S_EXEC:   w_next_state = (w_is_load || w_is_store) ? S_MEM : S_WB;
      S_MEM: begin
        if (memReady)          w_next_state = w_is_load ? S_WB : S_FETCH;
        else if (w_mem_expire) w_next_state = S_TRAP;
      end
      S_WB:     w_next_state = S_FETCH;
      S_HALT:   w_next_state = S_HALT;
      S_TRAP:   w_next_state = S_TRAP;
      default:  w_next_state = S_FETCH;
    endcase
  end

  // Everything is forced low while reset is held so an aborted access drops at once.
  always_comb begin
    instrReq     = 1'b0;
    irLoad       = 1'b0;
    regWrite     = 1'b0;
    memRead      = 1'b0;
    memWrite     = 1'b0;
    aluSrcImm    = 1'b0;
    aluControl   = '0;
    pcWrite      = 1'b0;
    ecall        = 1'b0;
    illegalInstr = 1'b0;
    memTimeout   = 1'b0;
    state        = 3'd0;
    if (rst_n) begin
      illegalInstr = r_illegal;
      memTimeout   = r_timeout;
      state        = r_state;
      case (r_state)
        S_FETCH: begin
          instrReq = 1'b1;
          irLoad   = instrValid;
        end
        S_DECODE: ecall = w_is_ecall;
        S_EXEC: begin
          aluSrcImm  = w_use_imm;
          aluControl = w_alu;
        end
        S_MEM: begin
          aluControl = w_alu;
          memRead    = w_is_load;
          memWrite   = w_is_store;
          pcWrite    = w_is_store && memReady;
        end
        S_WB: begin
          aluControl = w_alu;
          regWrite   = (w_rd != 5'd0);
          pcWrite    = 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed bench for multicycle_controller: stimulus queues per-cycle expected outputs,
// an independent monitor pops and compares them on the falling edge.
module tb_multicycle_controller;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        instrValid = 1'b0;
    logic [31:0] instr = 32'd0;
    logic        memReady = 1'b0;
    logic        instrReq, irLoad, regWrite, memRead, memWrite, aluSrcImm;
    logic [3:0]  aluControl;
    logic        pcWrite, ecall, illegalInstr, memTimeout;
    logic [2:0]  state;

    multicycle_controller #(.WORD(32), .ALU_W(4), .MEM_TIMEOUT(15)) dut (
        .clk(clk), .rst_n(rst_n), .instrValid(instrValid), .instr(instr),
        .memReady(memReady), .instrReq(instrReq), .irLoad(irLoad),
        .regWrite(regWrite), .memRead(memRead), .memWrite(memWrite),
        .aluSrcImm(aluSrcImm), .aluControl(aluControl), .pcWrite(pcWrite),
        .ecall(ecall), .illegalInstr(illegalInstr), .memTimeout(memTimeout),
        .state(state)
    );

    always #5 clk = ~clk;

    logic [16:0] exp_q[$];
    string       name_q[$];
    int          compared = 0;
    int          mismatched = 0;

    // Vector layout: {state, instrReq, irLoad, regWrite, memRead, memWrite, aluSrcImm,
    //                 aluControl, pcWrite, ecall, illegalInstr, memTimeout}
    function automatic logic [16:0] ev(input int st, input int req, input int irl, input int rw,
                                       input int mrd, input int mwr, input int imm, input int alu,
                                       input int pcw, input int ec, input int ill, input int to);
        ev = {3'(st), 1'(req), 1'(irl), 1'(rw), 1'(mrd), 1'(mwr), 1'(imm), 4'(alu),
              1'(pcw), 1'(ec), 1'(ill), 1'(to)};
    endfunction

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            logic [16:0] e;
            logic [16:0] a;
            string       nm;
            e  = exp_q.pop_front();
            nm = name_q.pop_front();
            a  = {state, instrReq, irLoad, regWrite, memRead, memWrite, aluSrcImm, aluControl,
                  pcWrite, ecall, illegalInstr, memTimeout};
            compared++;
            if (a !== e) begin
                mismatched++;
                $display("FAIL %s: got %05h required %05h", nm, a, e);
            end
        end
    end

    task automatic step(input logic r, input logic iv, input logic [31:0] ins, input logic mr,
                        input logic [16:0] e, input string nm);
        @(posedge clk);
        #1;
        rst_n = r; instrValid = iv; instr = ins; memReady = mr;
        exp_q.push_back(e);
        name_q.push_back(nm);
    endtask

    task automatic do_reset(input string nm);
        step(1'b0, 1'b1, 32'h0050_0093, 1'b1, ev(0,0,0,0,0,0,0,0,0,0,0,0), nm);
    endtask

    task automatic fetch_decode(input logic [31:0] ins, input string nm, input int ec);
        step(1'b1, 1'b1, ins, 1'b0, ev(0,1,1,0,0,0,0,0,0,0,0,0), {nm, "/fetch"});
        step(1'b1, 1'b1, ins, 1'b0, ev(1,0,0,0,0,0,0,0,0,ec,0,0), {nm, "/decode"});
    endtask

    task automatic run_alu(input logic [31:0] ins, input int alu, input int imm, input int rw,
                           input string nm);
        fetch_decode(ins, nm, 0);
        step(1'b1, 1'b1, ins, 1'b0, ev(2,0,0,0,0,0,imm,alu,0,0,0,0), {nm, "/exec"});
        step(1'b1, 1'b1, ins, 1'b0, ev(4,0,0,rw,0,0,0,alu,1,0,0,0), {nm, "/wb"});
        $display("[tb] %s issued %08h", nm, ins);
    endtask

    task automatic run_lw(input logic [31:0] ins, input int waits, input string nm);
        fetch_decode(ins, nm, 0);
        step(1'b1, 1'b0, ins, 1'b0, ev(2,0,0,0,0,0,1,0,0,0,0,0), {nm, "/exec"});
        for (int i = 0; i < waits; i++)
            step(1'b1, 1'b0, ins, 1'b0, ev(3,0,0,0,1,0,0,0,0,0,0,0), {nm, "/mem_wait"});
        step(1'b1, 1'b0, ins, 1'b1, ev(3,0,0,0,1,0,0,0,0,0,0,0), {nm, "/mem_ready"});
        step(1'b1, 1'b0, ins, 1'b0, ev(4,0,0,1,0,0,0,0,1,0,0,0), {nm, "/wb"});
        $display("[tb] %s issued %08h with %0d wait cycles", nm, ins, waits);
    endtask

    task automatic run_trap(input logic [31:0] ins, input string nm);
        fetch_decode(ins, nm, 0);
        for (int i = 0; i < 3; i++)
            step(1'b1, 1'b1, ins, 1'b1, ev(6,0,0,0,0,0,0,0,0,0,1,0), {nm, "/trap"});
        $display("[tb] %s issued %08h", nm, ins);
    endtask

    initial begin
        do_reset("reset");
        do_reset("reset_hold");
        run_alu(32'h0050_0093, 0, 1, 1, "ADDI");
        run_alu(32'h0020_81B3, 0, 0, 1, "ADD");
        run_alu(32'h4020_81B3, 1, 0, 1, "SUB");
        run_alu(32'h1234_50B7, 10, 1, 1, "LUI");
        run_alu(32'h4030_D113, 9, 1, 1, "SRAI");
        run_alu(32'h0000_0013, 0, 1, 0, "NOP");
        run_lw(32'h0000_A283, 3, "LW_w3");

        fetch_decode(32'h0050_A223, "SW", 0);
        step(1'b1, 1'b0, 32'h0, 1'b0, ev(2,0,0,0,0,0,1,0,0,0,0,0), "SW/exec");
        step(1'b1, 1'b0, 32'h0, 1'b1, ev(3,0,0,0,0,1,0,0,1,0,0,0), "SW/mem");
        step(1'b1, 1'b0, 32'h0, 1'b0, ev(0,1,0,0,0,0,0,0,0,0,0,0), "SW/no_wb");
        $display("[tb] SW issued 0050a223");

        run_lw(32'h0000_A283, 14, "LW_ready_at_limit");

        fetch_decode(32'h0050_A223, "SW_rst", 0);
        step(1'b1, 1'b0, 32'h0, 1'b0, ev(2,0,0,0,0,0,1,0,0,0,0,0), "SW_rst/exec");
        step(1'b1, 1'b0, 32'h0, 1'b0, ev(3,0,0,0,0,1,0,0,0,0,0,0), "SW_rst/mem");
        step(1'b0, 1'b0, 32'h0, 1'b1, ev(0,0,0,0,0,0,0,0,0,0,0,0), "SW_rst/abort");
        step(1'b1, 1'b0, 32'h0, 1'b0, ev(0,1,0,0,0,0,0,0,0,0,0,0), "SW_rst/fetch");
        $display("[tb] SW aborted by reset");

        run_trap(32'hFFFF_FFFF, "UNDEF");
        do_reset("reset_after_undef");
        run_trap(32'h4020_F1B3, "AND_f7");
        do_reset("reset_after_and");
        run_trap(32'h0000_8283, "LB");
        do_reset("reset_after_lb");

        fetch_decode(32'h0000_A283, "LW_timeout", 0);
        step(1'b1, 1'b0, 32'h0, 1'b0, ev(2,0,0,0,0,0,1,0,0,0,0,0), "LW_timeout/exec");
        for (int i = 0; i < 15; i++)
            step(1'b1, 1'b0, 32'h0, 1'b0, ev(3,0,0,0,1,0,0,0,0,0,0,0), "LW_timeout/mem");
        for (int i = 0; i < 3; i++)
            step(1'b1, 1'b1, 32'h0, 1'b1, ev(6,0,0,0,0,0,0,0,0,0,0,1), "LW_timeout/trap");
        $display("[tb] LW timeout trapped");
        do_reset("reset_after_timeout");

        fetch_decode(32'h0000_0073, "ECALL", 1);
        for (int i = 0; i < 20; i++)
            step(1'b1, 1'b1, 32'h0000_0073, 1'b1, ev(5,0,0,0,0,0,0,0,0,0,0,0), "ECALL/halt");
        $display("[tb] ECALL halted");
        do_reset("reset_after_halt");
        step(1'b1, 1'b0, 32'h0, 1'b0, ev(0,1,0,0,0,0,0,0,0,0,0,0), "final_fetch_idle");

        @(posedge clk);
        @(negedge clk);
        #1;
        if (compared == 0) begin
            mismatched++;
            $display("FAIL monitor: got 0 comparisons required at least 1");
        end
        if (exp_q.size() != 0) begin
            mismatched++;
            $display("FAIL monitor: got %0d pending expectations required 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        if (mismatched == 0) $display("PASS");
        else                 $display("FAIL %0d mismatches", mismatched);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, required completion before 200000");
        $fatal(1, "watchdog expired");
    end

endmodule
